// File: rtl/xosera_bus_master.sv
// xosera_bus_master
//   Bus initiator for the Xosera 8-bit register bus. Each 16-bit request is
//   split into two byte cycles (even/high byte first, then odd/low byte), each
//   framed by programmable setup, strobe and hold times.
//
//   Parameters: SETUP_CYC, STROBE_CYC, HOLD_CYC (1..15 cycles each)
//
//   Ports:
//     clk, reset_n        clock, synchronous active-low reset
//     req_valid_i/ready_o request handshake
//     req_write_i         1 = write, 0 = read
//     req_reg_i           register number
//     req_wdata_i         write data, [15:8] is the even byte
//     rsp_valid_o         one-cycle completion pulse
//     rsp_rdata_o         read data {byte0, byte1}, 0 for writes
//     xosera_*            registered bus pins toward the responder
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | ready for a request, bus parked with cs_n high
//   SETUP  | address/direction/data stable, cs_n high before strobe
//   STROBE | cs_n low, read byte sampled on the last strobe edge
//   HOLD   | cs_n high, bus fields held after strobe
//   DONE   | one-cycle response pulse
module xosera_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [3:0]  req_reg_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        xosera_cs_n,
  output logic        xosera_rd_nwr,
  output logic [3:0]  xosera_reg_num,
  output logic        xosera_bytesel,
  output logic [7:0]  xosera_data_o,
  input  logic [7:0]  xosera_data_i
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;

  function automatic logic [7:0] wr_byte(input logic wr, input logic [15:0] d, input logic b);
    if (!wr)
      return 8'h00;
    return b ? d[7:0] : d[15:8];
  endfunction

  // xosera_bytesel doubles as the byte index of the transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      wr_q           <= 1'b0;
      wdata_q        <= 16'h0000;
      rdata_q        <= 16'h0000;
      req_ready_o    <= 1'b0;
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= 16'h0000;
      xosera_cs_n    <= 1'b1;
      xosera_rd_nwr  <= 1'b1;
      xosera_reg_num <= 4'd0;
      xosera_bytesel <= 1'b0;
      xosera_data_o  <= 8'h00;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_ready_o && req_valid_i) begin
            req_ready_o    <= 1'b0;
            wr_q           <= req_write_i;
            wdata_q        <= req_wdata_i;
            rdata_q        <= 16'h0000;
            xosera_rd_nwr  <= ~req_write_i;
            xosera_reg_num <= req_reg_i;
            xosera_bytesel <= 1'b0;
            xosera_data_o  <= wr_byte(req_write_i, req_wdata_i, 1'b0);
            cnt            <= SETUP_LD;
            state          <= SETUP;
          end else begin
            // first IDLE cycle after reset raises ready
            req_ready_o <= 1'b1;
          end
        end

        SETUP: begin
          if (cnt == 4'd0) begin
            xosera_cs_n <= 1'b0;
            cnt         <= STROBE_LD;
            state       <= STROBE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        STROBE: begin
          if (cnt == 4'd0) begin
            if (!wr_q) begin
              if (xosera_bytesel)
                rdata_q[7:0] <= xosera_data_i;
              else
                rdata_q[15:8] <= xosera_data_i;
            end
            xosera_cs_n <= 1'b1;
            cnt         <= HOLD_LD;
            state       <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        HOLD: begin
          if (cnt == 4'd0) begin
            if (!xosera_bytesel) begin
              xosera_bytesel <= 1'b1;
              xosera_data_o  <= wr_byte(wr_q, wdata_q, 1'b1);
              cnt            <= SETUP_LD;
              state          <= SETUP;
            end else begin
              xosera_data_o <= 8'h00;
              rsp_valid_o   <= 1'b1;
              rsp_rdata_o   <= wr_q ? 16'h0000 : rdata_q;
              state         <= DONE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        DONE: begin
          rsp_rdata_o <= 16'h0000;
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xosera_bus_master.sv
// Testbench for xosera_bus_master: one default-timing instance and one with
// SETUP=2/STROBE=1/HOLD=3, selected by sel. Directed requests, per-cycle
// capture after each handshake, and a bus stability monitor.
module tb_xosera_bus_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sel;
  logic        req_valid, req_write;
  logic [3:0]  req_reg;
  logic [15:0] req_wdata;
  logic [7:0]  rd_hi, rd_lo;

  logic        valid_a, ready_a, rv_a, cs_a, rw_a, bs_a;
  logic [15:0] rd_a;
  logic [3:0]  reg_a;
  logic [7:0]  do_a, di_a;
  logic        valid_b, ready_b, rv_b, cs_b, rw_b, bs_b;
  logic [15:0] rd_b;
  logic [3:0]  reg_b;
  logic [7:0]  do_b, di_b;

  logic        m_cs, m_rw, m_bs, m_rv, m_rdy;
  logic [3:0]  m_reg;
  logic [7:0]  m_do;
  logic [15:0] m_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign valid_a = req_valid & ~sel;
  assign valid_b = req_valid & sel;
  // responder drives real data only while strobed
  assign di_a = !cs_a ? (bs_a ? rd_lo : rd_hi) : 8'hEE;
  assign di_b = !cs_b ? (bs_b ? rd_lo : rd_hi) : 8'hEE;

  assign m_cs  = sel ? cs_b    : cs_a;
  assign m_rw  = sel ? rw_b    : rw_a;
  assign m_bs  = sel ? bs_b    : bs_a;
  assign m_rv  = sel ? rv_b    : rv_a;
  assign m_rdy = sel ? ready_b : ready_a;
  assign m_reg = sel ? reg_b   : reg_a;
  assign m_do  = sel ? do_b    : do_a;
  assign m_rd  = sel ? rd_b    : rd_a;

  xosera_bus_master dut_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(valid_a), .req_ready_o(ready_a), .req_write_i(req_write),
    .req_reg_i(req_reg), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv_a), .rsp_rdata_o(rd_a),
    .xosera_cs_n(cs_a), .xosera_rd_nwr(rw_a), .xosera_reg_num(reg_a),
    .xosera_bytesel(bs_a), .xosera_data_o(do_a), .xosera_data_i(di_a)
  );

  xosera_bus_master #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(valid_b), .req_ready_o(ready_b), .req_write_i(req_write),
    .req_reg_i(req_reg), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv_b), .rsp_rdata_o(rd_b),
    .xosera_cs_n(cs_b), .xosera_rd_nwr(rw_b), .xosera_reg_num(reg_b),
    .xosera_bytesel(bs_b), .xosera_data_o(do_b), .xosera_data_i(di_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // per-cycle capture, index k = cycles after the handshake edge
  logic        c_cs[0:39], c_rw[0:39], c_bs[0:39], c_rv[0:39], c_rdy[0:39];
  logic [3:0]  c_reg[0:39];
  logic [7:0]  c_do[0:39];
  logic [15:0] c_rd[0:39];

  task automatic capture(input int m, input int drop_k, input int rst_on_k, input int rst_off_k);
    for (int k = 1; k <= m; k++) begin
      @(negedge clk);
      c_cs[k] = m_cs; c_rw[k] = m_rw; c_bs[k] = m_bs; c_rv[k] = m_rv;
      c_rdy[k] = m_rdy; c_reg[k] = m_reg; c_do[k] = m_do; c_rd[k] = m_rd;
      if (k == drop_k) req_valid = 1'b0;
      if (k == rst_on_k) reset_n = 1'b0;
      if (k == rst_off_k) reset_n = 1'b1;
    end
  endtask

  task automatic handshake(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (m_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_hs"}, 32'(ok), 32'd1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  // expected frame of one request starting after capture index base
  task automatic check_frame(input string nm, input int base, input logic wr,
                             input logic [3:0] rg, input logic [15:0] wd,
                             input logic [15:0] rexp, input int s, input int p, input int h);
    int n, j, i;
    logic b, ecs;
    logic [7:0] ed;
    n = s + p + h;
    for (int k = 1; k <= 2 * n + 1; k++) begin
      i = base + k;
      if (k <= 2 * n) begin
        b   = (k > n);
        j   = (k - 1) % n;
        ecs = !(j >= s && j < s + p);
        ed  = wr ? (b ? wd[7:0] : wd[15:8]) : 8'h00;
        chk($sformatf("%s_cs@%0d", nm, k), 32'(c_cs[i]), 32'(ecs));
        chk($sformatf("%s_bs@%0d", nm, k), 32'(c_bs[i]), 32'(b));
        chk($sformatf("%s_do@%0d", nm, k), 32'(c_do[i]), 32'(ed));
        chk($sformatf("%s_rw@%0d", nm, k), 32'(c_rw[i]), 32'(!wr));
        chk($sformatf("%s_reg@%0d", nm, k), 32'(c_reg[i]), 32'(rg));
        chk($sformatf("%s_rv@%0d", nm, k), 32'(c_rv[i]), 32'd0);
      end else begin
        chk($sformatf("%s_cs@%0d", nm, k), 32'(c_cs[i]), 32'd1);
        chk($sformatf("%s_rv@%0d", nm, k), 32'(c_rv[i]), 32'd1);
        chk($sformatf("%s_rdata", nm), 32'(c_rd[i]), 32'(rexp));
        chk($sformatf("%s_do@%0d", nm, k), 32'(c_do[i]), 32'd0);
        chk($sformatf("%s_rdy@%0d", nm, k), 32'(c_rdy[i]), 32'd0);
      end
    end
  endtask

  // bus monitor: fields frozen while cs_n low and in the cycle it rises,
  // rsp_valid never two cycles in a row; skipped right after a reset edge
  logic        rst_q;
  logic        p_cs, p_rv;
  logic [13:0] p_bus;
  always @(posedge clk) rst_q <= reset_n;
  always @(negedge clk) begin
    if (rst_q === 1'b1) begin
      if (p_cs === 1'b0)
        chk("mon_stable", 32'({m_rw, m_reg, m_bs, m_do}), 32'(p_bus));
      if (p_rv === 1'b1)
        chk("mon_rsp_pulse", 32'(m_rv), 32'd0);
    end
    p_cs  = m_cs;
    p_rv  = m_rv;
    p_bus = {m_rw, m_reg, m_bs, m_do};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    reset_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_reg = 4'd0; req_wdata = 16'h0000; rd_hi = 8'h12; rd_lo = 8'h34;

    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(m_cs), 32'd1);
    chk("rst_rw", 32'(m_rw), 32'd1);
    chk("rst_reg", 32'(m_reg), 32'd0);
    chk("rst_bs", 32'(m_bs), 32'd0);
    chk("rst_do", 32'(m_do), 32'd0);
    chk("rst_rdy", 32'(m_rdy), 32'd0);
    chk("rst_rv", 32'(m_rv), 32'd0);
    chk("rst_rd", 32'(m_rd), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(m_rdy), 32'd1);

    // write reg 3 = 0xA55A
    req_write = 1'b1; req_reg = 4'd3; req_wdata = 16'hA55A; req_valid = 1'b1;
    handshake("wr");
    capture(12, 1, 0, 0);
    check_frame("wr", 0, 1'b1, 4'd3, 16'hA55A, 16'h0000, 1, 3, 1);
    chk("wr_cs_low_t2", 32'(c_cs[2]), 32'd0);
    chk("wr_cs_low_t9", 32'(c_cs[9]), 32'd0);
    chk("wr_cs_high_t10", 32'(c_cs[10]), 32'd1);
    chk("wr_do_t3", 32'(c_do[3]), 32'h0A5);
    chk("wr_do_t8", 32'(c_do[8]), 32'h05A);
    chk("wr_rdy_t12", 32'(c_rdy[12]), 32'd1);

    // read reg 5, wdata must not reach the bus
    req_write = 1'b0; req_reg = 4'd5; req_wdata = 16'hFFFF; req_valid = 1'b1;
    handshake("rd");
    capture(12, 1, 0, 0);
    check_frame("rd", 0, 1'b0, 4'd5, 16'hFFFF, 16'h1234, 1, 3, 1);
    chk("rd_rdata_t11", 32'(c_rd[11]), 32'h1234);
    chk("rd_rdata_t10", 32'(c_rd[10]), 32'h0000);

    // back-to-back: write then read, fields changed during the first
    req_write = 1'b1; req_reg = 4'd6; req_wdata = 16'hBEEF; req_valid = 1'b1;
    rd_hi = 8'h56; rd_lo = 8'h78;
    handshake("b2b");
    req_write = 1'b0; req_reg = 4'd9; req_wdata = 16'h0000;
    capture(25, 13, 0, 0);
    check_frame("b2b0", 0, 1'b1, 4'd6, 16'hBEEF, 16'h0000, 1, 3, 1);
    chk("b2b_rdy_t11", 32'(c_rdy[11]), 32'd0);
    chk("b2b_rdy_t12", 32'(c_rdy[12]), 32'd1);
    chk("b2b_rdy_t13", 32'(c_rdy[13]), 32'd0);
    check_frame("b2b1", 12, 1'b0, 4'd9, 16'h0000, 16'h5678, 1, 3, 1);
    gap = 0;
    for (int k = 10; k <= 20; k++) begin
      if (c_cs[k] !== 1'b1) break;
      gap++;
    end
    chk("b2b_gap", 32'(gap), 32'd4);

    // reset during the second strobe cycle of byte 0
    rd_hi = 8'h12; rd_lo = 8'h34;
    req_write = 1'b0; req_reg = 4'd5; req_valid = 1'b1;
    handshake("ab");
    capture(20, 1, 3, 4);
    chk("ab_cs_t3", 32'(c_cs[3]), 32'd0);
    chk("ab_cs", 32'(c_cs[4]), 32'd1);
    chk("ab_rw", 32'(c_rw[4]), 32'd1);
    chk("ab_reg", 32'(c_reg[4]), 32'd0);
    chk("ab_bs", 32'(c_bs[4]), 32'd0);
    chk("ab_do", 32'(c_do[4]), 32'd0);
    chk("ab_rdy", 32'(c_rdy[4]), 32'd0);
    chk("ab_rd", 32'(c_rd[4]), 32'd0);
    chk("ab_rdy_t5", 32'(c_rdy[5]), 32'd1);
    for (int k = 4; k <= 20; k++) begin
      chk($sformatf("ab_no_rsp@%0d", k), 32'(c_rv[k]), 32'd0);
      chk($sformatf("ab_cs_hi@%0d", k), 32'(c_cs[k]), 32'd1);
    end

    rd_hi = 8'h9A; rd_lo = 8'hBC;
    req_write = 1'b0; req_reg = 4'd2; req_valid = 1'b1;
    handshake("rd2");
    capture(12, 1, 0, 0);
    check_frame("rd2", 0, 1'b0, 4'd2, 16'h0000, 16'h9ABC, 1, 3, 1);

    // non-default timing instance
    @(negedge clk);
    sel = 1'b1;
    req_write = 1'b1; req_reg = 4'hA; req_wdata = 16'hC33C; req_valid = 1'b1;
    handshake("nd");
    capture(15, 1, 0, 0);
    check_frame("nd", 0, 1'b1, 4'hA, 16'hC33C, 16'h0000, 2, 1, 3);
    chk("nd_cs_t2", 32'(c_cs[2]), 32'd1);
    chk("nd_cs_t3", 32'(c_cs[3]), 32'd0);
    chk("nd_cs_t4", 32'(c_cs[4]), 32'd1);
    chk("nd_cs_t9", 32'(c_cs[9]), 32'd0);
    chk("nd_rv_t12", 32'(c_rv[12]), 32'd0);
    chk("nd_rv_t13", 32'(c_rv[13]), 32'd1);
    chk("nd_rdy_t14", 32'(c_rdy[14]), 32'd1);

    rd_hi = 8'h0F; rd_lo = 8'hF0;
    req_write = 1'b0; req_reg = 4'h1; req_valid = 1'b1;
    handshake("nd_rd");
    capture(14, 1, 0, 0);
    check_frame("nd_rd", 0, 1'b0, 4'h1, 16'h0000, 16'h0FF0, 2, 1, 3);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
